// File: rtl/exc_track_if.sv
// exc_track_if: pipeline-side and CP0-side signals of the exception tracker.
// master = pipeline/CP0 driver, slave = exc_track.
interface exc_track_if #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned CODE_W = 5,
    parameter int unsigned PC_W   = 32
);
    logic                     in_valid;
    logic [PC_W-1:0]          in_pc;
    logic                     in_bd;
    logic                     stall;
    logic [STAGES-1:0]        inj_vld;
    logic [STAGES*CODE_W-1:0] inj_code;
    logic                     int_req;
    logic                     eret_commit;

    logic                     exc_take;
    logic                     flush;
    logic [PC_W-1:0]          epc;
    logic [CODE_W-1:0]        cause_code;
    logic                     cause_bd;
    logic                     exl;
    logic                     commit_exc;

    modport master (
        output in_valid, in_pc, in_bd, stall, inj_vld, inj_code, int_req, eret_commit,
        input  exc_take, flush, epc, cause_code, cause_bd, exl, commit_exc
    );

    modport slave (
        input  in_valid, in_pc, in_bd, stall, inj_vld, inj_code, int_req, eret_commit,
        output exc_take, flush, epc, cause_code, cause_bd, exl, commit_exc
    );
endinterface

// File: rtl/exc_track.sv
// exc_track: carries PC / delay-slot flag / first exception code down the
// pipe and takes exceptions and interrupts precisely at the commit stage.
// Optional feature macro: EXC_BD_EN (branch-delay-slot tracking for EPC/BD).
module exc_track #(
    parameter int unsigned STAGES      = 4,
    parameter int unsigned CODE_W      = 5,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned STALL_STAGE = 2,
    parameter int unsigned INT_CODE    = 0
) (
    input logic        clk,
    input logic        rst_n,
    exc_track_if.slave bus
);
    localparam int unsigned C = STAGES - 1;

    typedef enum logic [1:0] {s_run, s_take, s_exl} state_t;

    state_t            state;
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] has_exc;
    logic [PC_W-1:0]   pc   [STAGES];
    logic [CODE_W-1:0] code [STAGES];

    logic [STAGES-1:0] nxt_valid;
    logic [STAGES-1:0] nxt_has_exc;
    logic [PC_W-1:0]   nxt_pc   [STAGES];
    logic [CODE_W-1:0] nxt_code [STAGES];

    logic [STAGES-1:0] eff_exc_c;
    logic [CODE_W-1:0] eff_code_c [STAGES];
    logic              int_hit_c;
    logic              take_c;
    logic [PC_W-1:0]   epc_nxt_c;

    logic              exc_take_q;
    logic [PC_W-1:0]   epc_q;
    logic [CODE_W-1:0] cause_code_q;
    logic              exl_q;
    logic              commit_exc_q;

`ifdef EXC_BD_EN
    logic [STAGES-1:0] bd;
    logic [STAGES-1:0] nxt_bd;
    logic              cause_bd_q;
`else
    logic              unused_bd;
    assign unused_bd = bus.in_bd;
`endif

    // Per-stage effective exception: stored fault wins over a new local one.
    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            eff_exc_c[i]  = valid[i] & (has_exc[i] | bus.inj_vld[i]);
            eff_code_c[i] = has_exc[i] ? code[i] : bus.inj_code[i*CODE_W +: CODE_W];
        end
    end

    // Commit-stage take decision; interrupts only while no handler is active.
    assign int_hit_c = valid[C] & bus.int_req & (state == s_run);
    assign take_c    = (state != s_take) & (eff_exc_c[C] | int_hit_c);

`ifdef EXC_BD_EN
    assign epc_nxt_c = bd[C] ? (pc[C] - PC_W'(4)) : pc[C];
`else
    assign epc_nxt_c = pc[C];
`endif

    // Next pipe contents: advance, hold/bubble on stall, clear on flush.
    always_comb begin
        nxt_valid   = valid;
        nxt_has_exc = eff_exc_c;
        nxt_pc      = pc;
        nxt_code    = eff_code_c;
`ifdef EXC_BD_EN
        nxt_bd      = bd;
`endif
        if (state == s_take) begin
            nxt_valid   = '0;
            nxt_has_exc = '0;
        end else begin
            if (!bus.stall) begin
                nxt_valid[0]   = bus.in_valid;
                nxt_has_exc[0] = 1'b0;
                nxt_pc[0]      = bus.in_pc;
                nxt_code[0]    = '0;
`ifdef EXC_BD_EN
                nxt_bd[0]      = bus.in_bd;
`endif
            end else if (STALL_STAGE == 0) begin
                nxt_valid[0]   = 1'b0;
                nxt_has_exc[0] = 1'b0;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (!bus.stall || i > STALL_STAGE) begin
                    nxt_valid[i]   = valid[i-1];
                    nxt_has_exc[i] = eff_exc_c[i-1];
                    nxt_pc[i]      = pc[i-1];
                    nxt_code[i]    = eff_code_c[i-1];
`ifdef EXC_BD_EN
                    nxt_bd[i]      = bd[i-1];
`endif
                end else if (i == STALL_STAGE) begin
                    nxt_valid[i]   = 1'b0;
                    nxt_has_exc[i] = 1'b0;
                end
            end
        end
    end

    // Pipe registers and the registered commit-stage pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid        <= '0;
            has_exc      <= '0;
            pc           <= '{default: '0};
            code         <= '{default: '0};
            commit_exc_q <= 1'b0;
`ifdef EXC_BD_EN
            bd           <= '0;
`endif
        end else begin
            valid        <= nxt_valid;
            has_exc      <= nxt_has_exc;
            pc           <= nxt_pc;
            code         <= nxt_code;
            commit_exc_q <= nxt_valid[C] & nxt_has_exc[C];
`ifdef EXC_BD_EN
            bd           <= nxt_bd;
`endif
        end
    end

    // RUN / TAKE / EXL sequencer with CP0 capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= s_run;
            exc_take_q   <= 1'b0;
            epc_q        <= '0;
            cause_code_q <= '0;
            exl_q        <= 1'b0;
`ifdef EXC_BD_EN
            cause_bd_q   <= 1'b0;
`endif
        end else begin
            exc_take_q <= 1'b0;
            case (state)
                s_run, s_exl: begin
                    if (take_c) begin
                        state        <= s_take;
                        exc_take_q   <= 1'b1;
                        exl_q        <= 1'b1;
                        cause_code_q <= int_hit_c ? CODE_W'(INT_CODE) : eff_code_c[C];
`ifdef EXC_BD_EN
                        cause_bd_q   <= bd[C];
`endif
                        if (state == s_run) begin
                            epc_q <= epc_nxt_c;
                        end
                    end else if (state == s_exl && bus.eret_commit) begin
                        state <= s_run;
                        exl_q <= 1'b0;
                    end
                end
                s_take:  state <= s_exl;
                default: state <= s_run;
            endcase
        end
    end

    assign bus.exc_take   = exc_take_q;
    assign bus.flush      = exc_take_q;
    assign bus.epc        = epc_q;
    assign bus.cause_code = cause_code_q;
    assign bus.exl        = exl_q;
    assign bus.commit_exc = commit_exc_q;
`ifdef EXC_BD_EN
    assign bus.cause_bd   = cause_bd_q;
`else
    assign bus.cause_bd   = 1'b0;
`endif

endmodule

// File: tb/tb_exc_track.sv
// tb_exc_track: directed table, corner sequences and random traffic for
// exc_track, checked against an instruction-list reference model.
// Honours EXC_BD_EN the same way as the design.
module tb_exc_track;
    localparam int unsigned STAGES      = 4;
    localparam int unsigned CODE_W      = 5;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned STALL_STAGE = 2;
    localparam int unsigned INT_CODE    = 0;
    localparam int          C           = STAGES - 1;
`ifdef EXC_BD_EN
    localparam bit BD_ON = 1'b1;
`else
    localparam bit BD_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    exc_track_if #(.STAGES(STAGES), .CODE_W(CODE_W), .PC_W(PC_W)) bus ();

    exc_track #(
        .STAGES(STAGES), .CODE_W(CODE_W), .PC_W(PC_W),
        .STALL_STAGE(STALL_STAGE), .INT_CODE(INT_CODE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of in-flight instructions, oldest first.
    typedef struct {
        logic [PC_W-1:0]   pc;
        logic              bd;
        logic              exc;
        logic [CODE_W-1:0] code;
        int                pos;
    } instr_t;

    instr_t            q[$];
    logic              m_take, m_exl, m_bd, m_cexc;
    logic [PC_W-1:0]   m_epc;
    logic [CODE_W-1:0] m_code;

    task automatic model_reset();
        q.delete();
        m_take = 0; m_exl = 0; m_bd = 0; m_cexc = 0; m_epc = '0; m_code = '0;
    endtask

    task automatic model_step();
        instr_t t;
        logic   has_c, is_int;
        if (m_take) begin
            q.delete();
            m_take = 0;
            m_cexc = 0;
            return;
        end
        for (int k = 0; k < q.size(); k++) begin
            t = q[k];
            if (!t.exc && bus.inj_vld[t.pos]) begin
                t.exc  = 1'b1;
                t.code = bus.inj_code[t.pos*CODE_W +: CODE_W];
                q[k]   = t;
            end
        end
        has_c = (q.size() > 0) && (q[0].pos == C);
        if (has_c && (q[0].exc || (bus.int_req && !m_exl))) begin
            is_int = bus.int_req && !m_exl;
            m_code = is_int ? CODE_W'(INT_CODE) : q[0].code;
            if (!m_exl) m_epc = (BD_ON && q[0].bd) ? q[0].pc - 32'd4 : q[0].pc;
            m_bd   = BD_ON && q[0].bd;
            m_exl  = 1'b1;
            m_take = 1'b1;
        end else if (m_exl && bus.eret_commit) begin
            m_exl = 1'b0;
        end
        if (has_c) void'(q.pop_front());
        for (int k = 0; k < q.size(); k++) begin
            t = q[k];
            if (!bus.stall || t.pos >= int'(STALL_STAGE)) t.pos = t.pos + 1;
            q[k] = t;
        end
        if (!bus.stall && bus.in_valid) begin
            t.pc = bus.in_pc; t.bd = bus.in_bd; t.exc = 1'b0; t.code = '0; t.pos = 0;
            q.push_back(t);
        end
        m_cexc = (q.size() > 0) && (q[0].pos == C) && q[0].exc;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("exc_take",   64'(bus.exc_take),   64'(m_take));
        chk("flush",      64'(bus.flush),      64'(m_take));
        chk("epc",        64'(bus.epc),        64'(m_epc));
        chk("cause_code", 64'(bus.cause_code), 64'(m_code));
        chk("cause_bd",   64'(bus.cause_bd),   64'(m_bd));
        chk("exl",        64'(bus.exl),        64'(m_exl));
        chk("commit_exc", 64'(bus.commit_exc), 64'(m_cexc));
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_pc = '0; bus.in_bd = 0; bus.stall = 0;
        bus.inj_vld = '0; bus.inj_code = '0; bus.int_req = 0; bus.eret_commit = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Directed single-instruction scenarios.
    typedef struct {
        logic [PC_W-1:0]   pc;
        logic              bd;
        int                s1;
        logic [CODE_W-1:0] c1;
        int                s2;
        logic [CODE_W-1:0] c2;
        logic              intr;
        logic [PC_W-1:0]   exp_epc;
        logic [CODE_W-1:0] exp_code;
        logic              exp_bd;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int took;
        do_reset();
        bus.in_valid = 1; bus.in_pc = 32'h3000; bus.in_bd = 0;
        cycle();
        bus.in_pc = v.pc; bus.in_bd = v.bd;
        cycle();
        took = -1;
        for (int p = 0; p < C + 4 && took < 0; p++) begin
            bus.in_pc   = v.pc + 32'(4 * (p + 1));
            bus.in_bd   = 0;
            bus.inj_vld = '0;
            bus.int_req = 0;
            if (p == v.s1) begin
                bus.inj_vld[p] = 1'b1;
                bus.inj_code[p*CODE_W +: CODE_W] = v.c1;
            end
            if (p == v.s2) begin
                bus.inj_vld[p] = 1'b1;
                bus.inj_code[p*CODE_W +: CODE_W] = v.c2;
            end
            if (p == C && v.intr) bus.int_req = 1;
            cycle();
            if (bus.exc_take) took = p;
        end
        chk("take_cycle", 64'(took), 64'(C));
        chk("vec_epc",   64'(bus.epc),        64'(v.exp_epc));
        chk("vec_code",  64'(bus.cause_code), 64'(v.exp_code));
        chk("vec_bd",    64'(bus.cause_bd),   64'(v.exp_bd));
        chk("vec_exl",   64'(bus.exl),        64'd1);
        idle();
        cycle();
        chk("flush_clears", 64'(dut.valid), 64'd0);
        chk("pulse_one",    64'(bus.exc_take), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int took;
        total = 0;
        bad   = 0;
        vecs[0] = '{32'h3004, 1'b0, 1,  5'd12, -1, 5'd0,  1'b0, 32'h3004, 5'd12, 1'b0};
        vecs[1] = '{32'h3008, 1'b0, 0,  5'd10,  2, 5'd12, 1'b0, 32'h3008, 5'd10, 1'b0};
        vecs[2] = '{32'h3010, 1'b1, 3,  5'd4,  -1, 5'd0,  1'b0,
                    BD_ON ? 32'h300C : 32'h3010, 5'd4, BD_ON};
        vecs[3] = '{32'h3020, 1'b0, 2,  5'd7,  -1, 5'd0,  1'b1, 32'h3020, 5'(INT_CODE), 1'b0};
        vecs[4] = '{32'h3040, 1'b0, -1, 5'd0,  -1, 5'd0,  1'b1, 32'h3040, 5'(INT_CODE), 1'b0};
        vecs[5] = '{32'h0000, 1'b1, 3,  5'd31, -1, 5'd0,  1'b0,
                    BD_ON ? 32'hFFFF_FFFC : 32'h0, 5'd31, BD_ON};
        vecs[6] = '{32'h3044, 1'b0, 3,  5'd1,   0, 5'd2,  1'b0, 32'h3044, 5'd2, 1'b0};

        idle();
        rst_n = 1'b1;
        model_reset();
        #1;
        do_reset();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Interrupts ignored under EXL; eret+exception keeps EXL; eret re-arms.
        run_vec(vecs[0]);
        bus.in_valid = 1; bus.int_req = 1;
        for (int i = 0; i < int'(STAGES) + 3; i++) begin
            bus.in_pc = 32'h4000 + 32'(4 * i);
            cycle();
            chk("int_in_exl", 64'(bus.exc_take), 64'd0);
        end
        bus.int_req = 0; bus.eret_commit = 1;
        bus.inj_vld[C] = 1'b1; bus.inj_code[C*CODE_W +: CODE_W] = 5'd9;
        cycle();
        chk("eret_exc_take", 64'(bus.exc_take),   64'd1);
        chk("eret_exc_code", 64'(bus.cause_code), 64'd9);
        chk("eret_exc_epc",  64'(bus.epc),        64'h3004);
        chk("eret_exc_exl",  64'(bus.exl),        64'd1);
        idle();
        cycle();
        bus.eret_commit = 1;
        cycle();
        chk("eret_clears_exl", 64'(bus.exl), 64'd0);
        idle();
        bus.in_valid = 1;
        for (int i = 0; i < int'(STAGES); i++) begin
            bus.in_pc = 32'h5000 + 32'(4 * i);
            cycle();
        end
        bus.int_req = 1;
        took = 0;
        for (int i = 0; i < 4 && took == 0; i++) begin
            cycle();
            if (bus.exc_take) took = 1;
        end
        chk("int_after_eret",  64'(took), 64'd1);
        chk("int_after_code",  64'(bus.cause_code), 64'(INT_CODE));

        // Stall while the faulting instruction sits in stage 1.
        do_reset();
        bus.in_valid = 1;
        bus.in_pc = 32'h3000; cycle();
        bus.in_pc = 32'h3004; cycle();
        bus.in_pc = 32'h3008; cycle();
        bus.in_pc = 32'h300C; bus.stall = 1;
        bus.inj_vld[1] = 1'b1; bus.inj_code[1*CODE_W +: CODE_W] = 5'd12;
        cycle();
        chk("stall_bubble", 64'(dut.valid[STALL_STAGE]), 64'd0);
        bus.inj_vld = '0;
        cycle();
        cycle();
        chk("stall_hold", 64'(dut.valid[1]), 64'd1);
        bus.stall = 0;
        took = 0;
        for (int i = 0; i < 10 && took == 0; i++) begin
            bus.in_pc = 32'h3010 + 32'(4 * i);
            cycle();
            if (bus.exc_take) took = 1;
        end
        chk("stall_take", 64'(took), 64'd1);
        chk("stall_epc",  64'(bus.epc), 64'h3004);
        chk("stall_code", 64'(bus.cause_code), 64'd12);

        // Reset in the middle of the TAKE cycle.
        do_reset();
        bus.in_valid = 1;
        for (int i = 0; i < int'(STAGES); i++) begin
            bus.in_pc = 32'h6000 + 32'(4 * i);
            cycle();
        end
        bus.int_req = 1;
        cycle();
        chk("pre_reset_take", 64'(bus.exc_take), 64'd1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("post_reset_exl", 64'(bus.exl), 64'd0);
        end

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_pc       = {$urandom()} & 32'hFFFF_FFFC;
            bus.in_bd       = $urandom_range(0, 1) == 1;
            bus.stall       = ($urandom_range(0, 4) == 0);
            for (int s = 0; s < int'(STAGES); s++) begin
                bus.inj_vld[s] = ($urandom_range(0, 19) == 0);
                bus.inj_code[s*CODE_W +: CODE_W] = CODE_W'($urandom());
            end
            bus.int_req     = ($urandom_range(0, 15) == 0);
            bus.eret_commit = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exc_track.md
# exc_track

Parametrised exception-tracking pipeline for the P7 MIPS core. It carries each instruction's PC, delay-slot flag and first-detected exception code from fetch to commit, so every stage only reports a local fault. At the commit stage it takes exceptions and interrupts precisely, captures EPC/Cause/BD for CP0, and flushes the pipe. It sequences a RUN / TAKE / EXL state machine until `eret` commits.

## Interface
- `STAGES`, 4, number of tracked stages; 0 = D, `STAGES-1` = commit (M); legal range 2..8
- `CODE_W`, 5, exception code width
- `PC_W`, 32, PC width
- `STALL_STAGE`, 2, stages `< STALL_STAGE` hold on stall; stage `STALL_STAGE` receives a bubble
- `INT_CODE`, 0, code reported for interrupts
- `clk`, in, 1, clock
- `rst_n`, in, 1, asynchronous active-low reset
- `in_valid`, in, 1, instruction enters stage 0
- `in_pc`, in, `PC_W`, PC of entering instruction
- `in_bd`, in, 1, entering instruction is in a branch delay slot
- `stall`, in, 1, hazard stall
- `inj_vld`, in, `STAGES`, per-stage exception detected this cycle (bit i = stage i)
- `inj_code`, in, `STAGES*CODE_W`, per-stage code; slice i = bits `[i*CODE_W +: CODE_W]`
- `int_req`, in, 1, masked interrupt request from CP0
- `eret_commit`, in, 1, `eret` is in the commit stage
- `exc_take`, out, 1, exception taken this cycle (one-cycle pulse)
- `flush`, out, 1, equals `exc_take`; the pipeline clears all stages
- `epc`, out, `PC_W`, captured EPC
- `cause_code`, out, `CODE_W`, captured ExcCode
- `cause_bd`, out, 1, captured BD bit
- `exl`, out, 1, handler-active flag
- `commit_exc`, out, 1, commit stage holds a valid instruction with a pending exception

## Operation
- Per-stage registers: `valid`, `pc`, `bd`, `has_exc`, `code`. The stage's effective exception is `has_exc | inj_vld[i]`. The code is the stored one if `has_exc`, else `inj_code[i]`. The earliest stage wins; later injections are ignored.
- Advance, non-stalled: stage i+1 ← effective contents of stage i. Stage 0 ← `in_*` with `has_exc=0`.
- On stall: stages `< STALL_STAGE` hold, but may still absorb injections. Stage `STALL_STAGE` loads `valid=0`. Later stages advance.
- Take condition at the commit stage `c`:
  - a valid instruction with an effective exception, or
  - a valid instruction with `int_req` while `exl=0`.
- If both hold, the interrupt wins and `cause_code=INT_CODE`.
- FSM states:
  - RUN: on take → TAKE.
  - TAKE: `exc_take=1`, all stages cleared next edge → EXL.
  - EXL: `exl=1`, interrupts ignored. A synchronous exception still pulses `exc_take` and updates `cause_code` and `cause_bd`, but EPC is not updated. `eret_commit` → RUN.
- EPC on take from RUN: `pc[c]-4` if `bd[c]`, else `pc[c]`. Arithmetic is modulo 2^`PC_W`.
- `eret_commit` together with an exception on the same instruction: the exception wins, and the state stays EXL.
- A flush overrides stall and `in_valid`: every `valid` becomes 0 on the edge after `exc_take`.

## Timing
- Reset (asynchronous, immediate): all `valid`/`has_exc`=0, FSM=RUN, `exc_take=0`, `flush=0`, `epc=0`, `cause_code=0`, `cause_bd=0`, `exl=0`, `commit_exc=0`.
- `exc_take` is registered. It asserts in the cycle after the commit stage meets the take condition and lasts exactly one cycle. `epc`, `cause_*` and `exl` update on that same edge.
- Fault-to-take latency for an injection at stage i: `STAGES-1-i` advance cycles, plus 1.
- Reset asserted mid-TAKE or mid-EXL returns to RUN with no pulse.
- Back-to-back exceptions cannot occur: the flush empties the pipe, so the earliest next take is `STAGES+1` cycles later.

## Configuration
- `EXC_BD_EN` defined: BD tracking active as described above.
- `EXC_BD_EN` undefined: the `bd` registers are removed, `cause_bd` is tied to 0, and EPC is always `pc[c]`. `in_bd` is ignored.

## Test plan
- Reset, then in_valid stream with pc 0x3000, 0x3004…; `inj_vld[1]` with code 12 on pc 0x3004 → `exc_take` pulses 3 cycles later, `epc`=0x3004, `cause_code`=12, `exl`=1, all stages are invalid next cycle.
- Same instruction gets code 10 at stage 0 and code 12 at stage 2 → `cause_code`=10.
- Delay slot: pc 0x3010 with `in_bd=1` faults with code 4 → `epc`=0x300C, `cause_bd`=1. With `EXC_BD_EN` off → `epc`=0x3010, `cause_bd`=0.
- `int_req` while a faulting instruction commits → `cause_code`=0. `int_req` while `exl=1` → no take. `eret_commit` → `exl`=0, and a later `int_req` is taken.
- Stall during injection at stage 1: the instruction holds, the bubble reaches stage 2, and the exception is still taken with correct epc after the stall releases.
- `rst_n` low during the TAKE cycle → all outputs 0 immediately, FSM=RUN.
